// File: rtl/riscv_pkg.sv
// Shared core definitions: opcodes, load/store funct3 codes and LSU state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: access legality, byte enables,
// store data replication and load byte/half extraction with extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] bus_rdata_i,
  output logic        legal_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_lane_o,
  output logic [31:0] rdata_ext_o
);

  logic        f3_ok;
  logic        aligned;
  logic [31:0] shifted;

  // Legal = one direction only, funct3 valid for that direction, naturally aligned.
  always_comb begin
    f3_ok   = 1'b0;
    aligned = 1'b1;
    case (funct3_i)
      F3_B:  f3_ok = 1'b1;
      F3_H:  begin f3_ok = 1'b1;       aligned = ~addr_lo_i[0];        end
      F3_W:  begin f3_ok = 1'b1;       aligned = (addr_lo_i == 2'b00); end
      F3_BU: f3_ok = mem_read_i;
      F3_HU: begin f3_ok = mem_read_i; aligned = ~addr_lo_i[0];        end
      default: f3_ok = 1'b0;
    endcase
    legal_o = (mem_read_i ^ mem_write_i) & f3_ok & aligned;
  end

  // Byte enables and replicated store data; loads always read the whole word.
  always_comb begin
    be_o         = 4'b1111;
    wdata_lane_o = wdata_i;
    if (!mem_read_i) begin
      case (funct3_i[1:0])
        2'b00: begin be_o = 4'b0001 << addr_lo_i; wdata_lane_o = {4{wdata_i[7:0]}};  end
        2'b01: begin be_o = 4'b0011 << addr_lo_i; wdata_lane_o = {2{wdata_i[15:0]}}; end
        default: begin be_o = 4'b1111;            wdata_lane_o = wdata_i;            end
      endcase
    end
  end

  // Shift the addressed byte/half down to bit 0, then sign- or zero-extend.
  always_comb begin
    shifted = bus_rdata_i >> {addr_lo_i, 3'b000};
    case (funct3_i)
      F3_B:    rdata_ext_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_ext_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata_ext_o = {24'd0, shifted[7:0]};
      F3_HU:   rdata_ext_o = {16'd0, shifted[15:0]};
      default: rdata_ext_o = bus_rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding req/ack data bus master for the core.
// Optional wait-for-ack timeout is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata_out,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  lsu_state_e        state_q;
  logic              busy_q, done_q, fault_q;
  logic              bus_req_q, bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [3:0]        bus_be_q;
  logic [31:0]       bus_wdata_q;
  logic [31:0]       rdata_out_q;
  logic              is_load_q;
  logic [2:0]        f3_q;
  logic [1:0]        addr_lo_q;

  logic              legal_d;
  logic [3:0]        be_d;
  logic [31:0]       wdata_lane_d;
  logic [31:0]       rdata_ext_d;
  logic [2:0]        sel_f3;
  logic [1:0]        sel_addr_lo;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q;
`endif

  // In IDLE the aligner sees the live request; afterwards it decodes the latched one.
  always_comb begin
    sel_f3      = (state_q == ST_IDLE) ? funct3    : f3_q;
    sel_addr_lo = (state_q == ST_IDLE) ? addr[1:0] : addr_lo_q;
  end

  lsu_align u_align (
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .funct3_i     (sel_f3),
    .addr_lo_i    (sel_addr_lo),
    .wdata_i      (wdata),
    .bus_rdata_i  (bus_rdata),
    .legal_o      (legal_d),
    .be_o         (be_d),
    .wdata_lane_o (wdata_lane_d),
    .rdata_ext_o  (rdata_ext_d)
  );

  // Access FSM with registered bus and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'd0;
      rdata_out_q <= 32'd0;
      is_load_q   <= 1'b0;
      f3_q        <= 3'b000;
      addr_lo_q   <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q  <= 1'b0;
          fault_q <= 1'b0;
          if (start) begin
            is_load_q <= mem_read;
            f3_q      <= funct3;
            addr_lo_q <= addr[1:0];
            busy_q    <= 1'b1;
            if (legal_d) begin
              state_q     <= ST_REQ;
              bus_req_q   <= 1'b1;
              bus_we_q    <= mem_write;
              bus_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
              bus_be_q    <= be_d;
              bus_wdata_q <= wdata_lane_d;
`ifdef LSU_TIMEOUT_EN
              cnt_q       <= '0;
`endif
            end else begin
              state_q <= ST_RESP;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            state_q   <= ST_RESP;
            bus_req_q <= 1'b0;
            done_q    <= 1'b1;
            fault_q   <= 1'b0;
            if (is_load_q) rdata_out_q <= rdata_ext_d;
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            state_q   <= ST_RESP;
            bus_req_q <= 1'b0;
            done_q    <= 1'b1;
            fault_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          fault_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          fault_q   <= 1'b0;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign rdata_out = rdata_out_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, fault;
  logic [31:0] rdata_out;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .fault(fault), .rdata_out(rdata_out), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  // Issue one access and act as a slave that acks after ack_wait REQ cycles.
  // lat = cycles from the start edge to done (-1 if done never came).
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input int ack_wait,
                        output int lat, output bit flt, output int reqc);
    int w;
    lat = -1; flt = 1'b0; reqc = 0; w = 0;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    bus_rdata = rdat; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (done) begin lat = k; flt = fault; break; end
      if (bus_req) begin reqc++; bus_ack = (w == ack_wait); w++; end
      else bus_ack = 1'b0;
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    bus_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++; if ({busy, done, fault, bus_req} !== 4'b0000) begin errors++;
      $display("FAIL reset_ctrl busy/done/fault/req=%b required 0000", {busy, done, fault, bus_req}); end
    checks++; if (rdata_out !== 32'd0) begin errors++;
      $display("FAIL reset_rdata rdata_out=%h required 00000000", rdata_out); end
    checks++; if ({bus_we, bus_be} !== 5'd0 || bus_addr !== 32'd0 || bus_wdata !== 32'd0) begin errors++;
      $display("FAIL reset_bus we=%b be=%b addr=%h wdata=%h required all 0", bus_we, bus_be, bus_addr, bus_wdata); end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_store_word();
    int req_cnt = 0, busy_cnt = 0, done_cnt = 0, flt_cnt = 0;
    mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h100; wdata = 32'hDEADBEEF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (bus_addr !== 32'h100 || bus_be !== 4'b1111 || bus_wdata !== 32'hDEADBEEF || bus_we !== 1'b1) begin errors++;
      $display("FAIL sw_bus addr=%h be=%b wdata=%h we=%b required 00000100 1111 deadbeef 1", bus_addr, bus_be, bus_wdata, bus_we); end
    for (int k = 0; k < 10; k++) begin
      if (bus_req) req_cnt++;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (fault) flt_cnt++;
      bus_ack = (k == 3);
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
    checks++; if (req_cnt !== 4) begin errors++; $display("FAIL sw_req_cycles got %0d required 4", req_cnt); end
    checks++; if (busy_cnt !== 5) begin errors++; $display("FAIL sw_busy_cycles got %0d required 5", busy_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL sw_done_pulses got %0d required 1", done_cnt); end
    checks++; if (flt_cnt !== 0) begin errors++; $display("FAIL sw_fault got %0d required 0", flt_cnt); end
    $display("SW 0x100 deadbeef: req=%0d busy=%0d done=%0d", req_cnt, busy_cnt, done_cnt);
  endtask

  task automatic test_store_byte_half();
    int lat; bit flt; int reqc;
    mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b000; addr = 32'h103; wdata = 32'h000000A5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (bus_be !== 4'b1000 || bus_wdata !== 32'hA5A5A5A5 || bus_addr !== 32'h100) begin errors++;
      $display("FAIL sb_bus be=%b wdata=%h addr=%h required 1000 a5a5a5a5 00000100", bus_be, bus_wdata, bus_addr); end
    bus_ack = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    checks++; if (done !== 1'b1 || fault !== 1'b0) begin errors++;
      $display("FAIL sb_latency done=%b fault=%b required 1 0 two cycles after start", done, fault); end
    @(posedge clk); #1;
    $display("SB 0x103 a5: be=1000 checked");
    // SH to the upper half: enables 1100, half replicated
    mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b001; addr = 32'h302; wdata = 32'h0000BEEF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (bus_be !== 4'b1100 || bus_wdata !== 32'hBEEFBEEF) begin errors++;
      $display("FAIL sh_bus be=%b wdata=%h required 1100 beefbeef", bus_be, bus_wdata); end
    bus_ack = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(posedge clk); #1;
    $display("SH 0x302 beef: be=1100 checked");
  endtask

  task automatic test_loads();
    int lat; bit flt; int reqc;
    run_op(1'b1, 1'b0, 3'b000, 32'h202, 32'd0, 32'h12803456, 0, lat, flt, reqc);
    checks++; if (rdata_out !== 32'hFFFFFF80 || lat !== 2 || flt !== 1'b0) begin errors++;
      $display("FAIL lb rdata=%h lat=%0d fault=%b required ffffff80 2 0", rdata_out, lat, flt); end
    $display("LB 0x202 -> %h", rdata_out);
    run_op(1'b1, 1'b0, 3'b100, 32'h202, 32'd0, 32'h12803456, 1, lat, flt, reqc);
    checks++; if (rdata_out !== 32'h00000080 || lat !== 3) begin errors++;
      $display("FAIL lbu rdata=%h lat=%0d required 00000080 3", rdata_out, lat); end
    $display("LBU 0x202 -> %h", rdata_out);
    run_op(1'b1, 1'b0, 3'b101, 32'h202, 32'd0, 32'h12803456, 0, lat, flt, reqc);
    checks++; if (rdata_out !== 32'h00001280) begin errors++;
      $display("FAIL lhu rdata=%h required 00001280", rdata_out); end
    $display("LHU 0x202 -> %h", rdata_out);
    run_op(1'b1, 1'b0, 3'b001, 32'h200, 32'd0, 32'h00008001, 0, lat, flt, reqc);
    checks++; if (rdata_out !== 32'hFFFF8001) begin errors++;
      $display("FAIL lh rdata=%h required ffff8001", rdata_out); end
    $display("LH 0x200 -> %h", rdata_out);
    run_op(1'b1, 1'b0, 3'b010, 32'h204, 32'd0, 32'h87654321, 0, lat, flt, reqc);
    checks++; if (rdata_out !== 32'h87654321) begin errors++;
      $display("FAIL lw rdata=%h required 87654321", rdata_out); end
    $display("LW 0x204 -> %h", rdata_out);
    // a store must leave the load result alone
    run_op(1'b0, 1'b1, 3'b010, 32'h208, 32'h11111111, 32'hAAAAAAAA, 0, lat, flt, reqc);
    checks++; if (rdata_out !== 32'h87654321) begin errors++;
      $display("FAIL store_keeps_rdata rdata=%h required 87654321", rdata_out); end
    $display("SW 0x208 -> rdata_out kept %h", rdata_out);
  endtask

  task automatic test_faults();
    int lat; bit flt; int reqc;
    run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 32'hFFFFFFFF, 0, lat, flt, reqc);
    checks++; if (lat !== 1 || flt !== 1'b1 || reqc !== 0) begin errors++;
      $display("FAIL lw_misaligned lat=%0d fault=%b req=%0d required 1 1 0", lat, flt, reqc); end
    checks++; if (rdata_out !== 32'h87654321) begin errors++;
      $display("FAIL lw_misaligned_rdata rdata=%h required 87654321", rdata_out); end
    $display("LW 0x101 -> fault lat=%0d", lat);
    run_op(1'b1, 1'b1, 3'b010, 32'h100, 32'd0, 32'hFFFFFFFF, 0, lat, flt, reqc);
    checks++; if (lat !== 1 || flt !== 1'b1 || reqc !== 0) begin errors++;
      $display("FAIL rd_and_wr lat=%0d fault=%b req=%0d required 1 1 0", lat, flt, reqc); end
    $display("RD+WR -> fault lat=%0d", lat);
    run_op(1'b0, 1'b1, 3'b100, 32'h100, 32'd0, 32'd0, 0, lat, flt, reqc);
    checks++; if (lat !== 1 || flt !== 1'b1 || reqc !== 0) begin errors++;
      $display("FAIL store_f3_100 lat=%0d fault=%b req=%0d required 1 1 0", lat, flt, reqc); end
    $display("store funct3=100 -> fault");
    run_op(1'b0, 1'b1, 3'b001, 32'h101, 32'd0, 32'd0, 0, lat, flt, reqc);
    checks++; if (lat !== 1 || flt !== 1'b1 || reqc !== 0) begin errors++;
      $display("FAIL sh_misaligned lat=%0d fault=%b req=%0d required 1 1 0", lat, flt, reqc); end
    $display("SH 0x101 -> fault");
    // ack while idle must not produce any activity
    bus_ack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if ({busy, done, bus_req} !== 3'b000) begin errors++;
      $display("FAIL idle_ack busy/done/req=%b required 000", {busy, done, bus_req}); end
    bus_ack = 1'b0;
    $display("ack in IDLE ignored");
  endtask

  task automatic test_async_reset();
    int lat; bit flt; int reqc;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h40; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req bus_req=%b required 1", bus_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus_req, busy, done} !== 3'b000) begin errors++;
      $display("FAIL async_rst req/busy/done=%b required 000", {bus_req, busy, done}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_no_done done=%b required 0", done); end
    run_op(1'b1, 1'b0, 3'b010, 32'h0, 32'd0, 32'hCAFEF00D, 0, lat, flt, reqc);
    checks++; if (rdata_out !== 32'hCAFEF00D || lat !== 2 || flt !== 1'b0) begin errors++;
      $display("FAIL post_rst_lw rdata=%h lat=%0d fault=%b required cafef00d 2 0", rdata_out, lat, flt); end
    $display("reset mid-load, then LW 0x0 -> %h", rdata_out);
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int lat; bit flt; int reqc;
    run_op(1'b1, 1'b0, 3'b010, 32'h80, 32'd0, 32'h55555555, 1000, lat, flt, reqc);
    checks++; if (reqc !== 4 || lat !== 5 || flt !== 1'b1) begin errors++;
      $display("FAIL timeout req=%0d lat=%0d fault=%b required 4 5 1", reqc, lat, flt); end
    checks++; if (rdata_out !== 32'hCAFEF00D) begin errors++;
      $display("FAIL timeout_rdata rdata=%h required cafef00d", rdata_out); end
    bus_ack = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    checks++; if ({busy, done, bus_req} !== 3'b000) begin errors++;
      $display("FAIL late_ack busy/done/req=%b required 000", {busy, done, bus_req}); end
    $display("timeout: req=%0d lat=%0d fault=%b", reqc, lat, flt);
  endtask
`endif

  initial begin
    test_reset();
    test_store_word();
    test_store_byte_half();
    test_loads();
    test_faults();
    test_async_reset();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
